// File: rtl/wb_lsu.sv
// wb_lsu: Wishbone-style bus master shared by instruction fetch and data load/store.
// Replicates store data across byte lanes, extracts and extends load data, with an optional ack timeout.
module wb_lsu #(
    parameter int DW      = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 0
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    req_i,
    input  logic                    wr_i,
    input  logic [1:0]              size_i,
    input  logic                    signed_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [DW-1:0]           wdata_i,
    input  logic                    fetch_i,
    input  logic [AW-1:0]           faddr_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    fetch_done_o,
    output logic [DW-1:0]           rdata_o,
    output logic                    err_o,
    output logic [AW-$clog2(DW/8)-1:0] adr_o,
    output logic                    cyc_o,
    output logic                    stb_o,
    output logic [DW/8-1:0]         sel_o,
    output logic                    we_o,
    output logic                    vpa_o,
    output logic [DW-1:0]           dat_o,
    input  logic                    ack_i,
    input  logic [DW-1:0]           dat_i
);
    localparam int SW = DW / 8;
    localparam int LB = $clog2(SW);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;

    logic [1:0]       r_state;
    logic             r_pend;
    logic [AW-LB-1:0] r_fadr;
    logic [CW-1:0]    r_cnt;
    logic [LB-1:0]    r_off;
    logic [1:0]       r_size;
    logic             r_sgn;

    logic [4:0]       w_nbytes;
    logic [LB-1:0]    w_off;
    logic             w_bad;
    logic [SW-1:0]    w_sel;
    logic [DW-1:0]    w_wdat;
    logic [DW-1:0]    w_shift;
    logic             w_sign;
    logic [DW-1:0]    w_load;
    logic [AW-LB-1:0] w_fadr;
    logic             w_tmo;
    logic             w_unused;

    assign w_nbytes = 5'd1 << size_i;
    assign w_off    = addr_i[LB-1:0];
    // When N equals the bus width the truncated mask becomes all ones, which is still the right alignment test.
    assign w_bad    = (w_nbytes > 5'(SW)) || ((w_off & LB'(w_nbytes - 5'd1)) != '0);
    assign w_sel    = ((SW'(1) << w_nbytes) - SW'(1)) << w_off;

    always_comb begin
        w_wdat = '0;
        for (int b = 0; b < SW; b++)
            w_wdat[8*b +: 8] = wdata_i[8*(b & (int'(w_nbytes) - 1)) +: 8];
    end

    assign w_shift = dat_i >> {r_off, 3'b000};
    assign w_sign  = r_sgn & w_shift[(8 << r_size) - 1];

    always_comb begin
        w_load = '0;
        for (int b = 0; b < SW; b++)
            w_load[8*b +: 8] = (b < (1 << r_size)) ? w_shift[8*b +: 8] : {8{w_sign}};
    end

    assign w_fadr   = r_pend ? r_fadr : faddr_i[AW-1:LB];
    assign w_tmo    = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign w_unused = ^faddr_i[LB-1:0];

    assign busy_o = (r_state != S_IDLE) || r_pend;
    assign stb_o  = cyc_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state      <= S_IDLE;
            r_pend       <= 1'b0;
            r_fadr       <= '0;
            r_cnt        <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_sgn        <= 1'b0;
            done_o       <= 1'b0;
            fetch_done_o <= 1'b0;
            rdata_o      <= '0;
            err_o        <= 1'b0;
            adr_o        <= '0;
            cyc_o        <= 1'b0;
            sel_o        <= '0;
            we_o         <= 1'b0;
            vpa_o        <= 1'b0;
            dat_o        <= '0;
        end else begin
            done_o       <= 1'b0;
            fetch_done_o <= 1'b0;
            err_o        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    // A deferred fetch goes out before any new data request.
                    if (r_pend || (fetch_i && !req_i)) begin
                        r_pend  <= 1'b0;
                        r_state <= S_FETCH;
                        cyc_o   <= 1'b1;
                        sel_o   <= '1;
                        adr_o   <= w_fadr;
                        we_o    <= 1'b0;
                        vpa_o   <= 1'b1;
                    end else if (req_i) begin
                        if (fetch_i) begin
                            r_pend <= 1'b1;
                            r_fadr <= faddr_i[AW-1:LB];
                        end
                        if (w_bad) begin
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            r_off   <= w_off;
                            r_size  <= size_i;
                            r_sgn   <= signed_i;
                            cyc_o   <= 1'b1;
                            sel_o   <= w_sel;
                            adr_o   <= addr_i[AW-1:LB];
                            we_o    <= wr_i;
                            vpa_o   <= 1'b0;
                            dat_o   <= w_wdat;
                        end
                    end
                end
                S_DATA, S_FETCH: begin
                    if (ack_i) begin
                        r_state <= S_IDLE;
                        cyc_o   <= 1'b0;
                        we_o    <= 1'b0;
                        vpa_o   <= 1'b0;
                        done_o  <= 1'b1;
                        if (r_state == S_FETCH) begin
                            rdata_o      <= dat_i;
                            fetch_done_o <= 1'b1;
                        end else if (!we_o) begin
                            rdata_o <= w_load;
                        end
                    end else if (w_tmo) begin
                        r_state      <= S_IDLE;
                        cyc_o        <= 1'b0;
                        we_o         <= 1'b0;
                        vpa_o        <= 1'b0;
                        done_o       <= 1'b1;
                        err_o        <= 1'b1;
                        fetch_done_o <= (r_state == S_FETCH);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_lsu.md
Name: wb_lsu

Overview:
- Parametrised bus-master front end for the S64X7 core family: one Wishbone-style master port serving both instruction fetch and data load/store.
- Performs byte-lane steering: store data is replicated across lanes; load data is extracted and zero- or sign-extended.
- Handles ack wait states and an optional bus timeout.
- Sits between the core's execute stage and the system bus, replacing the hard-wired 64-bit lane logic.

Parameters:
- DW, 64, data bus width in bits; power of two, 16..128.
- AW, 64, byte-address width.
- TIMEOUT, 0, wait-state limit in cycles before an aborted cycle; 0 disables the limit.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous reset, active-low.
- req_i  in  1  data access request, sampled in IDLE.
- wr_i  in  1  1 = store, 0 = load.
- size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- signed_i  in  1  sign-extend load result.
- addr_i  in  AW  data byte address.
- wdata_i  in  DW  store data, right-justified.
- fetch_i  in  1  instruction fetch request.
- faddr_i  in  AW  fetch byte address.
- busy_o  out  1  unit not idle, or a fetch is pending.
- done_o  out  1  one-cycle completion pulse.
- fetch_done_o  out  1  marks the done_o pulse as belonging to a fetch.
- rdata_o  out  DW  load or fetch result, held until the next done_o.
- err_o  out  1  valid with done_o: misaligned access, oversize access, or timeout.
- adr_o  out  AW-LB  bus word address, where LB = log2(DW/8).
- cyc_o  out  1  bus cycle.
- stb_o  out  1  strobe; always equal to cyc_o.
- sel_o  out  DW/8  byte lane selects.
- we_o  out  1  write enable.
- vpa_o  out  1  instruction fetch cycle.
- dat_o  out  DW  write data.
- ack_i  in  1  bus acknowledge.
- dat_i  in  DW  bus read data.

Behaviour:
- Reset (reset_i low, asynchronous):
  - All outputs go to 0 immediately.
  - State goes to IDLE; the pending-fetch flag and the timeout counter clear.
  - Reset during an active bus cycle drops cyc_o at once; no done_o is generated.
- State machine: IDLE, DATA, FETCH. All bus outputs are registered.
- IDLE, req_i = 1:
  - Compute N = 1 << size_i and offset = addr_i[LB-1:0].
  - Error case (N > DW/8, or offset not a multiple of N): no bus cycle; next cycle done_o = 1, err_o = 1, rdata_o unchanged.
  - Otherwise go to DATA with:
    - sel_o = ((1<<N)-1) << offset
    - adr_o = addr_i[AW-1:LB]
    - we_o = wr_i, vpa_o = 0
    - dat_o = low N bytes of wdata_i replicated DW/(8N) times.
- IDLE, fetch_i = 1 and req_i = 0: go to FETCH with sel_o all ones, vpa_o = 1, we_o = 0, adr_o = faddr_i[AW-1:LB].
- IDLE, req_i and fetch_i both 1: the data access wins. The fetch address is latched and a pending flag is set. The fetch issues from IDLE on the cycle after the data access's done_o.
- DATA/FETCH:
  - cyc_o, stb_o and all bus fields are held stable until ack_i is sampled high.
  - The cycle after ack_i: cyc_o = 0, state = IDLE, done_o = 1, err_o = 0.
  - Load result: rdata_o = (dat_i >> 8*offset), masked to N bytes, then zero- or sign-extended to DW.
  - Store: rdata_o unchanged.
  - Fetch: rdata_o = dat_i and fetch_done_o = 1.
- Latency: request accepted at edge k → cyc_o high after k → ack_i seen at edge k+1 (zero wait states) → done_o after k+1. Each wait state adds one cycle.
- Timeout (TIMEOUT > 0):
  - The counter increments each cycle cyc_o is high with ack_i low.
  - When the count reaches TIMEOUT: drop cyc_o, pulse done_o with err_o = 1, leave rdata_o unchanged.
  - If ack_i arrives on the expiry cycle, ack wins.
- req_i and fetch_i are ignored outside IDLE, including while a fetch is pending. The core must hold them or re-issue after done_o. A pending fetch takes precedence over a new req_i in IDLE.
- busy_o = (state != IDLE) or pending.
- ack_i while cyc_o = 0 is ignored.

Test Plan:
- DW = 64: reset low mid-FETCH → cyc_o, vpa_o and done_o fall to 0 within the same cycle; after reset release, busy_o = 0.
- Store byte: addr 0x11111111, wdata 0x41, ack immediate → sel_o = 00000010, dat_o = 0x4141414141414141, we_o = 1, done_o 2 cycles after req_i.
- Load half signed: addr 0x55555552, dat_i = 0x0000000081000000, 3 wait states → sel_o = 00001100, rdata_o = 0xFFFFFFFFFFFF8100, done_o 5 cycles after req_i.
- Simultaneous req_i (store dword, addr 0x44444448) and fetch_i (faddr 0xE000000000000008) → data cycle first with sel_o = FF; then fetch cycle with vpa_o = 1, adr_o = 0xE000000000000008 (as a byte address); two done_o pulses, second with fetch_done_o = 1.
- Misaligned word load at addr 0x55555556 → no cyc_o; done_o = 1 and err_o = 1 next cycle. Also, DW = 32 with a dword request → err_o = 1.
- TIMEOUT = 4, ack_i never asserted → cyc_o high exactly 4 cycles, then done_o = 1 and err_o = 1. Repeat with ack_i on the 4th cycle → err_o = 0.
